debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised N-channel debouncer for buttons and switches. It is the successor to the single-channel 4-state debounce FSM.
- Adds the following per channel:
  - 2-flop input synchroniser.
  - Dedicated stability counter with a configurable debounce time.
  - Abort-on-bounce in the wait states.
  - Registered outputs, plus one-cycle rise and fall strobes.
- Sits between the board pins and the control FSMs, for example the clock/alarm setting logic.

Parameters:
- NUM_CH, 4: number of independent input channels (1..32).
- DB_CYCLES, 1000000: number of consecutive stable clk cycles required to accept a level change (>=2). The default is 10 ms at 100 MHz.
- CNT_W, $clog2(DB_CYCLES): width of each channel's stability counter. It is derived and must not be overridden.
- LONG_CYCLES, 100000000: number of stable-high cycles for a long-press pulse. Used only with DEBOUNCE_LONGPRESS_EN.

Ports:
- clk, input, 1: system clock.
- reset_count, input, 1: asynchronous, active-high reset; clock clk.
- sw, input, NUM_CH: raw, asynchronous button/switch levels.
- db, output, NUM_CH: debounced levels (registered).
- rise, output, NUM_CH: one-cycle strobe when db goes 0->1.
- fall, output, NUM_CH: one-cycle strobe when db goes 1->0.
- long_press, output, NUM_CH: one-cycle strobe after LONG_CYCLES of stable high. Tied to 0 when the feature is absent.

Behaviour:
- Reset (reset_count=1, async):
  - All synchroniser flops = 0.
  - Every channel state = ZERO, counters = 0.
  - db, rise, fall and long_press = 0.
- Synchroniser: sw_s[i] is sw[i] delayed through 2 flops.
- Channel FSM states and transitions (registered state, counter cnt):
  - ZERO (db=0):
    - sw_s=1 -> WAIT_ONE, cnt<=0.
    - Otherwise stay.
  - WAIT_ONE (db=0):
    - sw_s=0 -> ZERO (bounce abort, no strobe).
    - Else if cnt==DB_CYCLES-1 -> ONE.
    - Else cnt<=cnt+1.
  - ONE (db=1):
    - sw_s=0 -> WAIT_ZERO, cnt<=0.
    - Otherwise stay.
  - WAIT_ZERO (db=1):
    - sw_s=1 -> ONE (abort, no strobe).
    - Else if cnt==DB_CYCLES-1 -> ZERO.
    - Else cnt<=cnt+1.
- Output timing:
  - db is registered and updates on the same edge the FSM enters ONE or ZERO.
  - rise is high for exactly the one cycle after the WAIT_ONE->ONE edge. fall is the same for WAIT_ZERO->ZERO.
  - rise and fall are never high together on one channel.
- Latency:
  - A raw edge stable from before edge k gives db changed after edge k+3+DB_CYCLES.
  - Breakdown: 2 sync edges, 1 entry edge, then DB_CYCLES counting edges.
- Counter:
  - Saturates only via the state change; it never wraps.
  - It is cleared on entry to every WAIT state, so a bounce restarts the full interval.
- Channels are fully independent. Simultaneous changes on multiple channels produce simultaneous strobes.
- A reset asserted mid-wait discards progress. After release, a channel whose input is held high needs the full 3+DB_CYCLES cycles again.

Optional Feature:
- Macro DEBOUNCE_LONGPRESS_EN.
- Defined:
  - Each channel has an extra hold counter that counts while the state is ONE.
  - When the count reaches LONG_CYCLES-1, long_press pulses for 1 cycle, once per press.
  - The counter is cleared on leaving ONE.
  - A WAIT_ZERO->ONE abort resumes without clearing.
- Undefined: there is no hold counter, and long_press is driven constant 0.

Decomposition:
- Package debounce_pkg holds:
  - The state encoding: ZERO=2'b00, WAIT_ONE=2'b01, ONE=2'b10, WAIT_ZERO=2'b11.
  - A typedef for the state.
- Sub-module debounce_channel:
  - Contains one synchroniser, the FSM, the counter, the strobes and the optional hold logic.
  - The top instantiates it NUM_CH times in a generate loop.

Test Plan:
All scenarios use NUM_CH=4, DB_CYCLES=8 and LONG_CYCLES=20.
- Reset: sw=4'hF with reset_count held high -> db=0, rise=0, fall=0. Release the reset at edge 0 -> db=4'hF after edge 11, rise=4'hF for exactly one cycle.
- Bounce on press: sw[0] toggles 0/1 every 3 cycles for 30 cycles, then stays 1 -> no rise during the toggling; db[0]=1 exactly 11 edges after the final stable 1.
- Release and abort:
  - From db[1]=1, drop sw[1] to 0 for 5 cycles, then return to 1 -> db[1] stays 1 and no fall occurs.
  - A later stable 0 -> fall[1] pulses once, 11 edges after the change.
- Independence: sw[2] rises at cycle 0 and sw[3] rises at cycle 4 -> rise[2] after edge 11, rise[3] after edge 15; no crosstalk on db[1:0].
- Mid-operation reset: sw[0]=1, reset_count pulsed at cycle 6 (inside WAIT_ONE) -> db[0]=0 at the pulse and rises 11 edges after release.
- DEBOUNCE_LONGPRESS_EN: hold sw[0]=1 -> long_press[0] pulses once, 20 cycles after db[0] rises. Releasing and re-pressing re-arms it. With the macro undefined, long_press stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared state encoding and helpers for the multi-channel debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_ZERO      = 2'b00,
    ST_WAIT_ONE  = 2'b01,
    ST_ONE       = 2'b10,
    ST_WAIT_ZERO = 2'b11
  } db_state_e;

  // The upper state bit is the accepted level: ONE and WAIT_ZERO both report high.
  function automatic logic level_of(input db_state_e st);
    return st[1];
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, 4-state FSM with stability counter,
// registered level and edge strobes. Long-press hold logic under DEBOUNCE_LONGPRESS_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = $clog2(DB_CYCLES),
  parameter int LONG_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset_count,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             sw_s;
  db_state_e        state_r;
  db_state_e        state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             db_next_s;
  logic             rise_next_s;
  logic             fall_next_s;
  logic             db_r;
  logic             rise_r;
  logic             fall_r;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
    end
  end

  assign sw_s = sync2_r;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state_r <= ST_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Any disagreeing sample in a WAIT state aborts; entry clears the counter so a bounce restarts the interval.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_ZERO: begin
        if (sw_s) begin
          state_next_s = ST_WAIT_ONE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = ST_ZERO;
        end
      end
      ST_WAIT_ONE: begin
        if (!sw_s) begin
          state_next_s = ST_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = ST_ONE;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_ONE: begin
        if (!sw_s) begin
          state_next_s = ST_WAIT_ZERO;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = ST_ONE;
        end
      end
      ST_WAIT_ZERO: begin
        if (sw_s) begin
          state_next_s = ST_ONE;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = ST_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = ST_ZERO;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    db_next_s   = level_of(state_next_s);
    rise_next_s = (state_r == ST_WAIT_ONE)  && (state_next_s == ST_ONE);
    fall_next_s = (state_r == ST_WAIT_ZERO) && (state_next_s == ST_ZERO);
  end

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      db_r   <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      db_r   <= db_next_s;
      rise_r <= rise_next_s;
      fall_r <= fall_next_s;
    end
  end

  assign db   = db_r;
  assign rise = rise_r;
  assign fall = fall_r;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_next_s;
  logic              fired_r;
  logic              fired_next_s;
  logic              long_next_s;
  logic              long_r;

  // Hold count freezes in WAIT_ZERO so an aborted release resumes the same press.
  always_comb begin
    hold_next_s  = hold_r;
    fired_next_s = fired_r;
    long_next_s  = 1'b0;
    case (state_r)
      ST_ONE: begin
        if (hold_r == HOLD_LAST) begin
          if (!fired_r) begin
            long_next_s  = 1'b1;
            fired_next_s = 1'b1;
          end else begin
            long_next_s = 1'b0;
          end
        end else begin
          hold_next_s = hold_r + HOLD_ONE;
        end
      end
      ST_WAIT_ZERO: begin
        hold_next_s = hold_r;
      end
      default: begin
        hold_next_s  = HOLD_ZERO;
        fired_next_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      hold_r  <= HOLD_ZERO;
      fired_r <= 1'b0;
      long_r  <= 1'b0;
    end else begin
      hold_r  <= hold_next_s;
      fired_r <= fired_next_s;
      long_r  <= long_next_s;
    end
  end

  assign long_press = long_r;
`else
  localparam int long_cycles_unused = LONG_CYCLES;

  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer top: one debounce_channel per input bit.
// Optional long-press strobe enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = $clog2(DB_CYCLES),
  parameter int LONG_CYCLES = 100000000
) (
  input  logic              clk,
  input  logic              reset_count,
  input  logic [NUM_CH-1:0] sw,
  output logic [NUM_CH-1:0] db,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] long_press
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_channel (
      .clk        (clk),
      .reset_count(reset_count),
      .sw         (sw[i]),
      .db         (db[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .long_press (long_press[i])
    );
  end

endmodule
